// File: rtl/coarse_peak_finder_pkg.sv
// Shared definitions for the coarse peak finder.
// Bin index width defaults to the SiFH-wide Nb value (8),
// so the scan always covers the same bin range as the histogram BRAM.
// Contents: default widths, FSM state enum, helper for the bin count N.
package coarse_peak_finder_pkg;

  localparam int NB_DEFAULT = 8;

  localparam int CNT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } state_e;

  // Number of histogram bins covered by one scan (N = 2^NB).
  function automatic int num_bins(input int nb);
    return 1 << nb;
  endfunction

endpackage

// File: rtl/coarse_peak_finder_if.sv
// Histogram BRAM port bundle used by the coarse peak finder.
// master: the peak finder (drives read address/enable and clear writes).
// slave : the histogram BRAM (returns read data one cycle after rd_en).
// Signals: rd_en, rd_addr[NB], rd_data[CNT_W], wr_en, wr_addr[NB], wr_data[CNT_W].
interface coarse_peak_finder_if #(
  parameter int NB    = 8,
  parameter int CNT_W = 16
);
  logic             rd_en;
  logic [NB-1:0]    rd_addr;
  logic [CNT_W-1:0] rd_data;
  logic             wr_en;
  logic [NB-1:0]    wr_addr;
  logic [CNT_W-1:0] wr_data;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  rd_data
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output rd_data
  );
endinterface

// File: rtl/coarse_peak_finder_compare.sv
// peak_compare_reg: running maximum/index register for the peak scan.
// Ports: clk, res (sync, active-high), clr (sync clear to 0/0),
//   upd_en (a valid bin is presented), data/idx (bin count and index),
//   max_nxt/idx_nxt (value the register will hold after this edge).
// A strict greater-than compare means ties keep the earlier (lower) index.
module peak_compare_reg #(
  parameter int NB    = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             res,
  input  logic             clr,
  input  logic             upd_en,
  input  logic [CNT_W-1:0] data,
  input  logic [NB-1:0]    idx,
  output logic [CNT_W-1:0] max_nxt,
  output logic [NB-1:0]    idx_nxt
);
  logic [CNT_W-1:0] max_q, max_d;
  logic [NB-1:0]    idx_q, idx_d;

  always_comb begin
    max_d = max_q;
    idx_d = idx_q;
    if (upd_en && (data > max_q)) begin
      max_d = data;
      idx_d = idx;
    end
  end

  // The top level latches the final result in the same cycle as the last
  // compare, so it needs the post-update value rather than the register.
  assign max_nxt = max_d;
  assign idx_nxt = idx_d;

  always_ff @(posedge clk) begin
    if (res || clr) begin
      max_q <= '0;
      idx_q <= '0;
    end else begin
      max_q <= max_d;
      idx_q <= idx_d;
    end
  end
endmodule

// File: rtl/coarse_peak_finder.sv
// coarse_peak_finder: scans one pixel's coarse histogram (N = 2^NB bins)
// and reports the bin with the largest count, optionally zeroing each bin
// as it is read.
// Ports: clk, res (sync, active-high), start, clear_en (sampled with an
//   accepted start), bram (histogram BRAM master port), busy, peakCH,
//   peakCount, peakValid, peakDone (one-cycle result strobe).
// Timing from the accepting cycle C0: reads C1..CN, compares C2..C(N+1),
// peakDone in C(N+2), back in IDLE from C(N+3).
module coarse_peak_finder
  import coarse_peak_finder_pkg::*;
#(
  parameter int NB        = NB_DEFAULT,
  parameter int CNT_W     = CNT_W_DEFAULT,
  parameter int MIN_COUNT = 1
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  start,
  input  logic                  clear_en,
  coarse_peak_finder_if.master  bram,
  output logic                  busy,
  output logic [NB-1:0]         peakCH,
  output logic [CNT_W-1:0]      peakCount,
  output logic                  peakValid,
  output logic                  peakDone
);
  localparam int            N         = num_bins(NB);
  localparam logic [NB-1:0] LAST_ADDR = NB'(N - 1);

  state_e           state_q, state_d;
  logic             rd_en_q, rd_en_d;
  logic [NB-1:0]    rd_addr_q, rd_addr_d;
  logic             clear_q, clear_d;
  logic             cmp_valid_q, cmp_valid_d;
  logic [NB-1:0]    cmp_addr_q, cmp_addr_d;
  logic             wr_en_q, wr_en_d;
  logic             busy_q, busy_d;
  logic [NB-1:0]    peak_ch_q, peak_ch_d;
  logic [CNT_W-1:0] peak_count_q, peak_count_d;
  logic             peak_valid_q, peak_valid_d;
  logic             peak_done_q, peak_done_d;
  logic             cmp_clr;
  logic [CNT_W-1:0] max_nxt;
  logic [NB-1:0]    idx_nxt;

  peak_compare_reg #(
    .NB    (NB),
    .CNT_W (CNT_W)
  ) u_cmp (
    .clk     (clk),
    .res     (res),
    .clr     (cmp_clr),
    .upd_en  (cmp_valid_q),
    .data    (bram.rd_data),
    .idx     (cmp_addr_q),
    .max_nxt (max_nxt),
    .idx_nxt (idx_nxt)
  );

  // Next-state logic. The compare stage trails the read stage by exactly
  // one cycle (BRAM latency), so the compare valid/address and the clear
  // write are simply the previous cycle's read enable/address.
  always_comb begin
    state_d      = state_q;
    rd_en_d      = 1'b0;
    rd_addr_d    = rd_addr_q;
    clear_d      = clear_q;
    cmp_valid_d  = rd_en_q;
    cmp_addr_d   = rd_en_q ? rd_addr_q : cmp_addr_q;
    wr_en_d      = rd_en_q & clear_q;
    peak_ch_d    = peak_ch_q;
    peak_count_d = peak_count_q;
    peak_valid_d = peak_valid_q;
    peak_done_d  = 1'b0;
    cmp_clr      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SCAN;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
          clear_d   = clear_en;
          cmp_clr   = 1'b1;
        end
      end
      SCAN: begin
        if (rd_addr_q == LAST_ADDR) begin
          state_d = DRAIN;
        end else begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_addr_q + 1'b1;
        end
      end
      DRAIN: begin
        // Last bin is being compared now; capture the post-compare result.
        state_d      = DONE;
        peak_ch_d    = idx_nxt;
        peak_count_d = max_nxt;
        peak_valid_d = (max_nxt >= CNT_W'(MIN_COUNT));
        peak_done_d  = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // All state and outputs registered; reset returns everything to zero.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q      <= IDLE;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      clear_q      <= 1'b0;
      cmp_valid_q  <= 1'b0;
      cmp_addr_q   <= '0;
      wr_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      peak_ch_q    <= '0;
      peak_count_q <= '0;
      peak_valid_q <= 1'b0;
      peak_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      clear_q      <= clear_d;
      cmp_valid_q  <= cmp_valid_d;
      cmp_addr_q   <= cmp_addr_d;
      wr_en_q      <= wr_en_d;
      busy_q       <= busy_d;
      peak_ch_q    <= peak_ch_d;
      peak_count_q <= peak_count_d;
      peak_valid_q <= peak_valid_d;
      peak_done_q  <= peak_done_d;
    end
  end

  assign bram.rd_en   = rd_en_q;
  assign bram.rd_addr = rd_addr_q;
  assign bram.wr_en   = wr_en_q;
  assign bram.wr_addr = cmp_addr_q;
  assign bram.wr_data = '0;
  assign busy         = busy_q;
  assign peakCH       = peak_ch_q;
  assign peakCount    = peak_count_q;
  assign peakValid    = peak_valid_q;
  assign peakDone     = peak_done_q;
endmodule

// File: tb/tb_coarse_peak_finder.sv
// Self-checking bench for coarse_peak_finder (NB=4, N=16, CNT_W=16).
// A 1-cycle-latency BRAM model feeds the DUT; expected peaks are pushed to
// a queue at each start and popped by a monitor whenever peakDone fires.
module tb_coarse_peak_finder;
  localparam int NB    = 4;
  localparam int N     = 16;
  localparam int CNT_W = 16;

  typedef struct {
    int unsigned ch;
    int unsigned cnt;
    bit          vld;
  } exp_t;

  logic clk;
  logic res;
  logic start;
  logic clear_en;
  logic busy;
  logic [NB-1:0]    peakCH;
  logic [CNT_W-1:0] peakCount;
  logic peakValid;
  logic peakDone;

  coarse_peak_finder_if #(.NB(NB), .CNT_W(CNT_W)) bus ();

  coarse_peak_finder #(.NB(NB), .CNT_W(CNT_W), .MIN_COUNT(1)) dut (
    .clk       (clk),
    .res       (res),
    .start     (start),
    .clear_en  (clear_en),
    .bram      (bus),
    .busy      (busy),
    .peakCH    (peakCH),
    .peakCount (peakCount),
    .peakValid (peakValid),
    .peakDone  (peakDone)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  exp_t        expq[$];
  int unsigned ref_hist[N];
  int unsigned hist_in[N];
  logic [CNT_W-1:0] mem[N];
  logic [CNT_W-1:0] pre[N];
  logic [CNT_W-1:0] rd_q;
  bit  pre_go = 0;
  bit  active = 0;
  bit  scan_clr = 0;
  int  scan_start = 0;
  int unsigned held_ch = 0, held_cnt = 0;
  bit  held_vld = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Histogram BRAM model: registered read, write port for clearing,
  // plus a bench-only bulk preload.
  always @(posedge clk) begin
    if (pre_go) begin
      for (int i = 0; i < N; i++) mem[i] <= pre[i];
    end else if (bus.wr_en) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
    if (bus.rd_en) rd_q <= mem[bus.rd_addr];
  end
  assign bus.rd_data = rd_q;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic loadHist();
    for (int i = 0; i < N; i++) begin
      pre[i]      = CNT_W'(hist_in[i]);
      ref_hist[i] = hist_in[i];
    end
    pre_go = 1;
    tick(1);
    pre_go = 0;
  endtask

  // Reference: the peak is the largest count; among equal maxima the
  // lowest bin index wins; valid when the count reaches MIN_COUNT (1).
  task automatic applyStimulus(input bit clr);
    exp_t e;
    int unsigned mx;
    mx = 0;
    for (int i = 0; i < N; i++) if (ref_hist[i] > mx) mx = ref_hist[i];
    e.ch = 0;
    for (int i = N - 1; i >= 0; i--) if (ref_hist[i] == mx) e.ch = i;
    e.cnt = mx;
    e.vld = (mx >= 1);
    expq.push_back(e);
    if (clr) for (int i = 0; i < N; i++) ref_hist[i] = 0;
    scan_start = cyc;
    scan_clr   = clr;
    active     = 1;
    start      = 1;
    clear_en   = clr;
    tick(1);
    start    = 0;
    clear_en = 1'($urandom_range(0, 1));
  endtask

  // Cycle-accurate protocol monitor and result scoreboard.
  always @(negedge clk) begin
    int rel;
    bit exp_rd, exp_wr, exp_busy, exp_done;
    exp_t e;
    if (res) begin
      held_ch  = 0;
      held_cnt = 0;
      held_vld = 0;
      expq.delete();
    end else begin
      rel      = active ? (cyc - scan_start) : -1;
      exp_rd   = (rel >= 1) && (rel <= N);
      exp_busy = (rel >= 1) && (rel <= N + 2);
      exp_wr   = scan_clr && (rel >= 2) && (rel <= N + 1);
      exp_done = (rel == N + 2);
      checkOutput("rd_en", 32'(bus.rd_en), 32'(exp_rd));
      checkOutput("busy", 32'(busy), 32'(exp_busy));
      checkOutput("wr_en", 32'(bus.wr_en), 32'(exp_wr));
      checkOutput("peakDone", 32'(peakDone), 32'(exp_done));
      if (exp_rd) checkOutput("rd_addr", 32'(bus.rd_addr), 32'(rel - 1));
      if (exp_wr) begin
        checkOutput("wr_addr", 32'(bus.wr_addr), 32'(rel - 2));
        checkOutput("wr_data", 32'(bus.wr_data), 32'd0);
      end
      if (peakDone === 1'b1) begin
        if (expq.size() == 0) begin
          checkOutput("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = expq.pop_front();
          held_ch  = e.ch;
          held_cnt = e.cnt;
          held_vld = e.vld;
        end
      end
      checkOutput("peakCH", 32'(peakCH), held_ch);
      checkOutput("peakCount", 32'(peakCount), held_cnt);
      checkOutput("peakValid", 32'(peakValid), 32'(held_vld));
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish (got timeout, expected $finish)");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    res      = 1;
    start    = 0;
    clear_en = 0;
    tick(3);
    res = 0;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_rd_en", 32'(bus.rd_en), 32'd0);
    checkOutput("rst_wr_en", 32'(bus.wr_en), 32'd0);
    checkOutput("rst_peakDone", 32'(peakDone), 32'd0);
    checkOutput("rst_peakValid", 32'(peakValid), 32'd0);
    checkOutput("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
    checkOutput("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    checkOutput("rst_peakCH", 32'(peakCH), 32'd0);
    checkOutput("rst_peakCount", 32'(peakCount), 32'd0);
    tick(2);

    // Single peak at bin 9
    for (int i = 0; i < N; i++) hist_in[i] = 3;
    hist_in[9] = 500;
    loadHist();
    applyStimulus(0);
    tick(N + 3);

    // Tie between the edge bins at full scale, then only the last bin
    for (int i = 0; i < N; i++) hist_in[i] = 10;
    hist_in[0]  = 16'hFFFF;
    hist_in[15] = 16'hFFFF;
    loadHist();
    applyStimulus(0);
    tick(N + 3);
    hist_in[0] = 10;
    loadHist();
    applyStimulus(0);
    tick(N + 3);

    // All-zero histogram
    for (int i = 0; i < N; i++) hist_in[i] = 0;
    loadHist();
    applyStimulus(0);
    tick(N + 3);

    // Clear mode, then a rescan of the cleared histogram
    for (int i = 0; i < N; i++) hist_in[i] = $urandom_range(1, 1000);
    loadHist();
    applyStimulus(1);
    tick(N + 3);
    applyStimulus(0);
    tick(N + 3);

    // Starts during a scan (C5 and C18) are ignored; C19 is accepted
    for (int i = 0; i < N; i++) hist_in[i] = $urandom_range(0, 300);
    loadHist();
    applyStimulus(0);
    tick(4);
    start    = 1;
    clear_en = 1;
    tick(1);
    start    = 0;
    clear_en = 0;
    tick(12);
    start = 1;
    tick(1);
    applyStimulus(0);
    tick(N + 3);

    // Reset at C8 of a scan; then a fresh scan
    for (int i = 0; i < N; i++) hist_in[i] = $urandom_range(0, 300);
    loadHist();
    applyStimulus(0);
    tick(7);
    res = 1;
    tick(1);
    res    = 0;
    active = 0;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_rd_en", 32'(bus.rd_en), 32'd0);
    checkOutput("midrst_wr_en", 32'(bus.wr_en), 32'd0);
    checkOutput("midrst_peakCH", 32'(peakCH), 32'd0);
    checkOutput("midrst_peakCount", 32'(peakCount), 32'd0);
    tick(5);
    applyStimulus(0);
    tick(N + 3);

    // Randomized scans, including duplicated maxima and random clearing
    for (int t = 0; t < 12; t++) begin
      int unsigned big;
      for (int i = 0; i < N; i++) hist_in[i] = $urandom_range(0, 200);
      if ($urandom_range(0, 1) == 1) begin
        big = $urandom_range(0, 65535);
        hist_in[$urandom_range(0, N - 1)] = big;
        hist_in[$urandom_range(0, N - 1)] = big;
      end
      loadHist();
      applyStimulus(1'($urandom_range(0, 1)));
      tick(N + 3 + $urandom_range(0, 2));
    end

    tick(5);
    checkOutput("pending_done", 32'(expq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/coarse_peak_finder.md
Name: coarse_peak_finder

Overview:
- Upstream neighbour of the algebraic threshold stage in the SiFH dTOF pipeline.
- After each coarse acquisition, scans one pixel's coarse histogram (2^NB bins) in the histogram BRAM and finds the bin with the maximum count.
- Presents that bin as peakCH, with a one-cycle peakDone strobe that the algebraic stage uses to latch its THminus/THpositive/delta window.
- Can optionally zero each bin as it is read, leaving the BRAM clean for the next acquisition.

Parameters:
- NB, 8, bin index width; must equal `Nb; the scan covers N = 2^NB bins.
- CNT_W, 16, histogram count width (BRAM data width).
- MIN_COUNT, 1, minimum peak count for peakValid=1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- res  in  1  reset; synchronous, active-high.
- start  in  1  scan request; accepted only in IDLE.
- clear_en  in  1  sampled together with an accepted start; 1 = zero each bin after it is read.
- rd_en  out  1  histogram BRAM read enable.
- rd_addr  out  NB  histogram BRAM read address.
- rd_data  in  CNT_W  BRAM read data, valid exactly 1 cycle after rd_en.
- wr_en  out  1  BRAM write enable, used for clearing.
- wr_addr  out  NB  BRAM write address.
- wr_data  out  CNT_W  BRAM write data; always 0.
- busy  out  1  high in every state except IDLE.
- peakCH  out  NB  index of the maximum bin.
- peakCount  out  CNT_W  count of the maximum bin.
- peakValid  out  1  peakCount >= MIN_COUNT.
- peakDone  out  1  one-cycle strobe; peakCH/peakCount/peakValid are valid in that cycle.

Behaviour:
- Reset values:
  - State IDLE.
  - busy, rd_en, wr_en, peakDone, peakValid = 0.
  - rd_addr, wr_addr, peakCH, peakCount = 0.
  - Internal running max and running index cleared.
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE -> SCAN when start=1. Call the accepting cycle C0.
  - On entering SCAN: latch clear_en, clear the running max to 0 and the running index to 0.
- SCAN (cycles C1..CN):
  - rd_en=1.
  - rd_addr = 0, 1, ..., N-1, one address per cycle.
  - The last address is followed by DRAIN.
- Compare pipeline:
  - rd_data for address k arrives in cycle C(k+2), k = 0..N-1, i.e. cycles C2..C(N+1).
  - In each of those cycles, if rd_data > running max (strict, unsigned), the running max and index update to rd_data and k.
  - Ties keep the lower index.
- DRAIN (cycle C(N+1)):
  - rd_en=0.
  - Final compare of bin N-1.
  - Next state DONE.
- DONE (cycle C(N+2)):
  - peakDone=1, with peakCH, peakCount and peakValid registered on entry.
  - Next state IDLE; busy drops in C(N+3).
- Total latency: peakDone occurs N+2 cycles after the start cycle.
- Output hold:
  - peakCH, peakCount and peakValid stay stable after DONE until the next DONE or reset.
  - They are not cleared by a new start.
- Clear mode (latched clear_en=1):
  - In each compare cycle C2..C(N+1): wr_en=1, wr_addr = the address whose data is being compared, wr_data = 0.
  - Each write lands after that address's read has completed, so there is no read-after-write hazard.
  - wr_en=0 in all other cycles and whenever latched clear_en=0.
- start while busy: ignored, not queued. clear_en is sampled only with an accepted start.
- start in the same cycle that DONE returns to IDLE: ignored. A new scan is accepted only from cycle C(N+3).
- All-zero histogram: peakCH=0, peakCount=0, peakValid=0 (when MIN_COUNT >= 1). peakDone still pulses.
- Maximum value: a count of (2^CNT_W)-1 is handled with no overflow; the compare is unsigned over the full width.
- res=1 mid-scan:
  - Next cycle is IDLE with all outputs at reset values.
  - No further rd_en or wr_en.
  - A partially cleared BRAM is allowed; software re-clears it.
- peakDone is exactly one cycle wide, never back-to-back.

Decomposition:
- Shared package (alongside parametersSiFH.vh):
  - NB/CNT_W defaults tied to `Nb.
  - State enum {IDLE, SCAN, DRAIN, DONE}.
  - The N = 1<<NB constant.
- One natural sub-module, peak_compare_reg: running max/index register with strict-greater update and synchronous clear.
- The FSM, address counter and clear-write path stay in the top level.

Test Plan (NB=4, N=16, CNT_W=16, MIN_COUNT=1; BRAM model with 1-cycle read latency):
- Single peak: bin 9 = 500, all others 3; start at C0 -> peakDone only at C18; peakCH=9, peakCount=500, peakValid=1; rd_addr walks 0..15 over C1..C16.
- Tie plus edge bins: bins 0 and 15 = 0xFFFF, others 10 -> peakCH=0, peakCount=0xFFFF. Then only bin 15 = 0xFFFF -> peakCH=15.
- All zero -> peakDone at C18 with peakCH=0, peakCount=0, peakValid=0.
- Clear mode: clear_en=1 with start -> wr_en high in C2..C17 with wr_addr 0..15 and wr_data 0; a rescan gives peakCount=0. With clear_en=0, wr_en never asserts.
- start pulsed at C5 and at C18 during a scan -> ignored: exactly one peakDone, busy is continuous C1..C18, and a start at C19 is accepted.
- res asserted at C8 mid-scan -> C9: IDLE, busy=0, rd_en=0, wr_en=0, peakCH=0, peakCount=0; no peakDone follows. A fresh start then completes normally.
